// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
// Consumes the value of a free-running 4-bit asynchronous ripple counter.
// The raw bus goes through a two-flop synchronizer and a stability filter, so
// only values that hold across the filter window are accepted. Each accepted
// change is step-checked: a legal step is +1 mod 16, and 15 -> 0 also counts
// as a roll-over. The accepted value also drives an active-low 7-segment digit.
module ripple_count_monitor #(
    parameter int STABLE_CYCLES = 2,   // legal range 1..15
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic [3:0]        count_in,   // asynchronous to clk
    input  logic              clr_err,
    output logic [3:0]        count_q,
    output logic              upd_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              skip_err,
    output logic [6:0]        hex_n
);

    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [6:0] HEX_ZERO  = 7'b1000000;

    // Active-low {g,f,e,d,c,b,a} glyphs for a hex digit.
    function automatic logic [6:0] hex_decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [3:0]        r_cand;
    logic [3:0]        r_stab_cnt;
    logic [3:0]        r_count_q;
    logic              r_upd_pulse;
    logic              r_wrap_pulse;
    logic [WRAP_W-1:0] r_wrap_count;
    logic              r_skip_err;
    logic [6:0]        r_hex_n;

    logic [3:0]        w_cand_next;
    logic [3:0]        w_stab_next;
    logic              w_accept;
    logic              w_change;
    logic              w_step_ok;
    logic              w_wrap;
    logic [3:0]        w_count_next;
    logic [6:0]        w_hex_next;

    // Bring the raw bus into the clk domain; nothing sits between the stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so r_sync2 gets the old r_sync1, not count_in.
            r_sync1 <= count_in;
            r_sync2 <= r_sync1;
        end
    end

    // Stability filter: restart on any difference, accept once the window fills.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_cand_next = r_cand;
        w_stab_next = r_stab_cnt;
        w_accept    = 1'b0;
        if (r_sync2 != r_cand) begin
            w_cand_next = r_sync2;
            w_stab_next = '0;
        end else if (r_stab_cnt == STAB_LAST) begin
            w_accept = 1'b1;
        end else begin
            w_stab_next = r_stab_cnt + 4'd1;
        end
    end

    // Step check of an accepted change and the next displayed value.
    always_comb begin
        w_change     = w_accept && (r_cand != r_count_q);
        w_step_ok    = (r_cand == r_count_q + 4'd1);
        w_wrap       = w_change && (r_count_q == 4'hF) && (r_cand == 4'h0);
        w_count_next = w_change ? r_cand : r_count_q;
        w_hex_next   = hex_decode(w_count_next);
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand     <= '0;
            r_stab_cnt <= '0;
        end else begin
            r_cand     <= w_cand_next;
            r_stab_cnt <= w_stab_next;
        end
    end

    // Accepted value, display, pulses, roll-over count and sticky skip flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count_q    <= '0;
            r_hex_n      <= HEX_ZERO;
            r_upd_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= '0;
            r_skip_err   <= 1'b0;
        end else begin
            r_count_q    <= w_count_next;
            r_hex_n      <= w_hex_next;
            r_upd_pulse  <= w_change;
            r_wrap_pulse <= w_wrap;
            if (w_wrap) begin
                r_wrap_count <= r_wrap_count + {{(WRAP_W-1){1'b0}}, 1'b1};
            end
            // A new illegal step outranks a clear sampled on the same edge.
            if (w_change && !w_step_ok) begin
                r_skip_err <= 1'b1;
            end else if (clr_err) begin
                r_skip_err <= 1'b0;
            end
        end
    end

    assign count_q    = r_count_q;
    assign upd_pulse  = r_upd_pulse;
    assign wrap_pulse = r_wrap_pulse;
    assign wrap_count = r_wrap_count;
    assign skip_err   = r_skip_err;
    assign hex_n      = r_hex_n;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: directed vectors, a behavioural model that
// accepts a value once the last STABLE_CYCLES+1 synchronized samples agree,
// a per-cycle compare against that model, and hand-computed literal checks.
module tb_ripple_count_monitor;

    localparam int S = 2;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   count_in = 4'd0;
    logic         clr_err = 1'b0;
    logic [3:0]   count_q;
    logic         upd_pulse;
    logic         wrap_pulse;
    logic [W-1:0] wrap_count;
    logic         skip_err;
    logic [6:0]   hex_n;

    int errors = 0;
    int checks = 0;
    int n_upd  = 0;
    int n_wrap = 0;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    ripple_count_monitor #(.STABLE_CYCLES(S), .WRAP_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .clr_err    (clr_err),
        .count_q    (count_q),
        .upd_pulse  (upd_pulse),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .skip_err   (skip_err),
        .hex_n      (hex_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw samples in, synchronized view is two edges late.
    int           raw[$];
    int           syncd[$];
    logic [3:0]   m_q    = 4'd0;
    logic         m_upd  = 1'b0;
    logic         m_wrap = 1'b0;
    logic [W-1:0] m_wc   = '0;
    logic         m_err  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw.delete();
            syncd.delete();
            m_q    <= 4'd0;
            m_upd  <= 1'b0;
            m_wrap <= 1'b0;
            m_wc   <= '0;
            m_err  <= 1'b0;
        end else begin : model_step
            int s;
            bit stable;
            bit bad;
            raw.push_back(int'(count_in));
            s = (raw.size() >= 3) ? raw[raw.size()-3] : 0;
            syncd.push_back(s);
            stable = (syncd.size() >= S + 1);
            if (stable) begin
                for (int k = 1; k <= S; k++) begin
                    if (syncd[syncd.size()-1-k] != s) stable = 1'b0;
                end
            end
            bad = 1'b0;
            m_upd  <= 1'b0;
            m_wrap <= 1'b0;
            if (stable && s != int'(m_q)) begin
                m_q   <= 4'(s);
                m_upd <= 1'b1;
                if (s != (int'(m_q) + 1) % 16) bad = 1'b1;
                if (m_q == 4'd15 && s == 0) begin
                    m_wrap <= 1'b1;
                    m_wc   <= m_wc + 1'b1;
                end
            end
            if (bad) m_err <= 1'b1;
            else if (clr_err) m_err <= 1'b0;
            if (raw.size() > 32) void'(raw.pop_front());
            if (syncd.size() > 32) void'(syncd.pop_front());
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        check("count_q", count_q, m_q);
        check("upd_pulse", upd_pulse, m_upd);
        check("wrap_pulse", wrap_pulse, m_wrap);
        check("wrap_count", wrap_count, m_wc);
        check("skip_err", skip_err, m_err);
        check("hex_n", hex_n, glyph[m_q]);
        if (upd_pulse) n_upd++;
        if (wrap_pulse) n_wrap++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input int v, input int hold);
        count_in = 4'(v);
        tick(hold);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        count_in = 4'd0;
        clr_err  = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        int n0;
        int w0;
        #1;
        do_reset();

        // Reset state.
        check("rst_count_q", count_q, 4'd0);
        check("rst_upd", upd_pulse, 1'b0);
        check("rst_wrap", wrap_pulse, 1'b0);
        check("rst_wrap_count", wrap_count, 0);
        check("rst_skip_err", skip_err, 1'b0);
        check("rst_hex", hex_n, 7'b1000000);

        // 0 -> 1: visible after the 5th edge, one-cycle pulse.
        count_in = 4'd1;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check("latency_hold", count_q, 4'd0);
        end
        tick(1);
        check("latency_q", count_q, 4'd1);
        check("latency_upd", upd_pulse, 1'b1);
        check("latency_hex", hex_n, 7'b1111001);
        check("latency_err", skip_err, 1'b0);
        tick(1);
        check("upd_one_cycle", upd_pulse, 1'b0);

        // Full sweep 0..15 then 0.
        do_reset();
        n0 = n_upd;
        w0 = n_wrap;
        for (int v = 0; v < 16; v++) drive(v, 10);
        drive(0, 10);
        check("sweep_upd_count", n_upd - n0, 16);
        check("sweep_wrap_pulses", n_wrap - w0, 1);
        check("sweep_wrap_count", wrap_count, 1);
        check("sweep_skip_err", skip_err, 1'b0);

        // Ripple transients 7 -> 6 -> 4 -> 8 never accepted.
        do_reset();
        for (int v = 1; v <= 7; v++) drive(v, 10);
        n0 = n_upd;
        drive(6, 1);
        drive(4, 1);
        drive(8, 10);
        check("glitch_upd_count", n_upd - n0, 1);
        check("glitch_q", count_q, 4'd8);
        check("glitch_hex", hex_n, 7'b0000000);
        check("glitch_skip_err", skip_err, 1'b0);

        // Skip 3 -> 9, clear, then set and clear on the same edge.
        do_reset();
        for (int v = 1; v <= 3; v++) drive(v, 10);
        check("skip_pre_q", count_q, 4'd3);
        drive(9, 10);
        check("skip_q", count_q, 4'd9);
        check("skip_err_set", skip_err, 1'b1);
        check("skip_hex", hex_n, 7'b0010000);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("skip_err_clr", skip_err, 1'b0);
        count_in = 4'd15;
        tick(4);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("set_wins_q", count_q, 4'd15);
        check("set_wins_err", skip_err, 1'b1);
        check("set_wins_hex", hex_n, 7'b0001110);

        // Reset mid-filter clears outputs before the next edge.
        count_in = 4'd1;
        tick(2);
        #1;
        rst = 1'b0;
        #1;
        check("async_q", count_q, 4'd0);
        check("async_err", skip_err, 1'b0);
        check("async_hex", hex_n, 7'b1000000);
        check("async_upd", upd_pulse, 1'b0);
        check("async_wrap_count", wrap_count, 0);
        tick(1);
        rst = 1'b1;
        n0 = n_upd;
        tick(8);
        check("post_rst_q", count_q, 4'd1);
        check("post_rst_err", skip_err, 1'b0);
        check("post_rst_upd_count", n_upd - n0, 1);

        // Roll-over counter wraps modulo 2^W.
        do_reset();
        for (int r = 0; r < (1 << W); r++) begin
            if (r == (1 << W) - 1) check("wrap_count_max", wrap_count, (1 << W) - 1);
            for (int v = 1; v < 16; v++) drive(v, 5);
            drive(0, 5);
        end
        check("wrap_count_rollover", wrap_count, 0);
        check("wrap_skip_err", skip_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
